// File: rtl/uart_rx_deser_param.sv
// UART receive deserializer: collects DATA_W data bits, an optional parity bit and a stop bit.
// It emits a one-cycle data_valid for each frame, with parity and stop error flags.
module uart_rx_deser_param #(
  parameter int DATA_W     = 8,
  parameter int MSB_FIRST  = 0,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              sampled_bit,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] p_data,
  output logic              data_valid,
  output logic              par_err,
  output logic              stop_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CNT_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              par_pend;
  logic              frame_start, shift_en, par_cap, done;

  function automatic logic parity_exp(input logic [DATA_W-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  function automatic logic [CNT_W-1:0] map_idx(input logic [CNT_W-1:0] c);
    return (MSB_FIRST != 0) ? (LAST_IDX - c) : c;
  endfunction

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    frame_start = 1'b0;
    shift_en    = 1'b0;
    par_cap     = 1'b0;
    done        = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_nxt   = DATA;
          cnt_nxt     = '0;
          frame_start = 1'b1;
        end
        DATA: if (sample_valid) begin
          shift_en = 1'b1;
          cnt_nxt  = cnt + CNT_W'(1);
          if (cnt == LAST_IDX) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        end
        PARITY: if (sample_valid) begin
          par_cap   = 1'b1;
          state_nxt = STOP;
        end
        STOP: if (sample_valid) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Write the incoming bit into its slot without indexing the register by a wider counter.
  always_comb begin
    bit_idx   = map_idx(cnt);
    shreg_nxt = shreg;
    for (int i = 0; i < DATA_W; i++) begin
      if (bit_idx == CNT_W'(i)) shreg_nxt[i] = sampled_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      par_pend   <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      data_valid <= done;
      if (shift_en) shreg <= shreg_nxt;
      if (frame_start) par_pend <= 1'b0;
      else if (par_cap) par_pend <= (sampled_bit != parity_exp(shreg));
      // Frame delivery: outputs hold until the next completed frame.
      if (done) begin
        p_data   <= shreg;
        par_err  <= (PARITY_EN != 0) && par_pend;
        stop_err <= ~sampled_bit;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deser_param.sv
// Scoreboard bench for uart_rx_deser_param across four parameter sets.
// Instances: default, MSB-first, even parity, and 5-bit data.
module tb_uart_rx_deser_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst[4], start[4], abort[4], sbit[4], sv[4];
  logic dv[4], pe[4], se[4], bz[4];
  logic [7:0] pd0, pd1, pd2;
  logic [4:0] pd3;

  typedef struct {
    logic [15:0] d;
    logic        pe;
    logic        se;
  } exp_t;

  exp_t exp_q[4][$];
  int   checks = 0;
  int   errors = 0;

  uart_rx_deser_param u0 (
    .clk(clk), .reset(rst[0]), .start(start[0]), .abort(abort[0]),
    .sampled_bit(sbit[0]), .sample_valid(sv[0]), .p_data(pd0),
    .data_valid(dv[0]), .par_err(pe[0]), .stop_err(se[0]), .busy(bz[0]));

  uart_rx_deser_param #(.MSB_FIRST(1)) u1 (
    .clk(clk), .reset(rst[1]), .start(start[1]), .abort(abort[1]),
    .sampled_bit(sbit[1]), .sample_valid(sv[1]), .p_data(pd1),
    .data_valid(dv[1]), .par_err(pe[1]), .stop_err(se[1]), .busy(bz[1]));

  uart_rx_deser_param #(.PARITY_EN(1), .PARITY_ODD(0)) u2 (
    .clk(clk), .reset(rst[2]), .start(start[2]), .abort(abort[2]),
    .sampled_bit(sbit[2]), .sample_valid(sv[2]), .p_data(pd2),
    .data_valid(dv[2]), .par_err(pe[2]), .stop_err(se[2]), .busy(bz[2]));

  uart_rx_deser_param #(.DATA_W(5)) u3 (
    .clk(clk), .reset(rst[3]), .start(start[3]), .abort(abort[3]),
    .sampled_bit(sbit[3]), .sample_valid(sv[3]), .p_data(pd3),
    .data_valid(dv[3]), .par_err(pe[3]), .stop_err(se[3]), .busy(bz[3]));

  function automatic logic [15:0] get_pd(input int idx);
    case (idx)
      0:       return {8'h00, pd0};
      1:       return {8'h00, pd1};
      2:       return {8'h00, pd2};
      default: return {11'h000, pd3};
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected frame per data_valid pulse.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dv[i] === 1'b1) begin
        if (exp_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_data_valid: inst %0d p_data %0h expected no frame", i, get_pd(i));
        end else begin
          exp_t e;
          e = exp_q[i].pop_front();
          chk($sformatf("p_data[%0d]", i), get_pd(i), e.d);
          chk($sformatf("par_err[%0d]", i), {15'h0, pe[i]}, {15'h0, e.pe});
          chk($sformatf("stop_err[%0d]", i), {15'h0, se[i]}, {15'h0, e.se});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input int idx, input logic b);
    sbit[idx] = b;
    sv[idx]   = 1'b1;
    tick();
    sv[idx]   = 1'b0;
    tick();
    tick();
  endtask

  // Sends one frame; stream[i] is the i-th bit on the line. glitch>=0 pulses start with that data bit.
  task automatic frame(input int idx, input logic [15:0] stream, input int nbits,
                       input logic has_par, input logic parbit, input logic stopbit,
                       input logic [15:0] exp_d, input logic exp_pe, input logic exp_se,
                       input int glitch, input logic b2b);
    exp_t e;
    e.d = exp_d; e.pe = exp_pe; e.se = exp_se;
    exp_q[idx].push_back(e);
    start[idx] = 1'b1;
    tick();
    start[idx] = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch) start[idx] = 1'b1;
      sbit[idx] = stream[i];
      sv[idx]   = 1'b1;
      tick();
      sv[idx]    = 1'b0;
      start[idx] = 1'b0;
      tick();
      tick();
    end
    if (has_par) send_bit(idx, parbit);
    sbit[idx]  = stopbit;
    sv[idx]    = 1'b1;
    start[idx] = b2b;
    tick();
    sv[idx]    = 1'b0;
    start[idx] = 1'b0;
    chk($sformatf("dv_latency[%0d]", idx), {15'h0, dv[idx]}, 16'h1);
    chk($sformatf("busy_drop[%0d]", idx), {15'h0, bz[idx]}, 16'h0);
    tick();
    chk($sformatf("dv_one_cycle[%0d]", idx), {15'h0, dv[idx]}, 16'h0);
    chk($sformatf("busy_idle[%0d]", idx), {15'h0, bz[idx]}, 16'h0);
    chk($sformatf("p_data_hold[%0d]", idx), get_pd(idx), exp_d);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; abort[i] = 1'b0; sbit[i] = 1'b1; sv[i] = 1'b0;
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_p_data[%0d]", i), get_pd(i), 16'h0);
      chk($sformatf("rst_dv[%0d]", i), {15'h0, dv[i]}, 16'h0);
      chk($sformatf("rst_par_err[%0d]", i), {15'h0, pe[i]}, 16'h0);
      chk($sformatf("rst_stop_err[%0d]", i), {15'h0, se[i]}, 16'h0);
      chk($sformatf("rst_busy[%0d]", i), {15'h0, bz[i]}, 16'h0);
    end

    // Samples in IDLE are ignored.
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    chk("idle_sample_busy", {15'h0, bz[0]}, 16'h0);

    // Default LSB-first frame: bits 1,0,1,1,0,0,1,0.
    frame(0, 16'h004D, 8, 1'b0, 1'b0, 1'b1, 16'h004D, 1'b0, 1'b0, -1, 1'b0);
    // MSB-first with the same stream.
    frame(1, 16'h004D, 8, 1'b0, 1'b0, 1'b1, 16'h00B2, 1'b0, 1'b0, -1, 1'b0);
    // Even parity: 0x4D has four ones.
    frame(2, 16'h004D, 8, 1'b1, 1'b0, 1'b1, 16'h004D, 1'b0, 1'b0, -1, 1'b0);
    frame(2, 16'h004D, 8, 1'b1, 1'b1, 1'b1, 16'h004D, 1'b1, 1'b0, -1, 1'b0);
    frame(2, 16'h0081, 8, 1'b1, 1'b0, 1'b1, 16'h0081, 1'b0, 1'b0, -1, 1'b0);
    // Stop error then a clean frame clears it.
    frame(0, 16'h003C, 8, 1'b0, 1'b0, 1'b0, 16'h003C, 1'b0, 1'b1, -1, 1'b0);
    frame(0, 16'h0081, 8, 1'b0, 1'b0, 1'b1, 16'h0081, 1'b0, 1'b0, -1, 1'b0);

    // Abort after four data bits, then a full frame.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    chk("abort_busy", {15'h0, bz[0]}, 16'h0);
    chk("abort_p_data_kept", get_pd(0), 16'h0081);
    frame(0, 16'h00A5, 8, 1'b0, 1'b0, 1'b1, 16'h00A5, 1'b0, 1'b0, -1, 1'b0);

    // start mid-frame is ignored; start coinciding with the stop sample is ignored.
    frame(0, 16'h0096, 8, 1'b0, 1'b0, 1'b1, 16'h0096, 1'b0, 1'b0, 3, 1'b0);
    frame(0, 16'h005A, 8, 1'b0, 1'b0, 1'b1, 16'h005A, 1'b0, 1'b0, -1, 1'b1);

    // 5-bit instance: a frame, then reset mid-DATA, then another frame.
    frame(3, 16'h000A, 5, 1'b0, 1'b0, 1'b0, 16'h000A, 1'b0, 1'b1, -1, 1'b0);
    start[3] = 1'b1;
    tick();
    start[3] = 1'b0;
    send_bit(3, 1'b1);
    send_bit(3, 1'b1);
    rst[3] = 1'b1;
    tick();
    rst[3] = 1'b0;
    chk("midrst_p_data", get_pd(3), 16'h0);
    chk("midrst_dv", {15'h0, dv[3]}, 16'h0);
    chk("midrst_par_err", {15'h0, pe[3]}, 16'h0);
    chk("midrst_stop_err", {15'h0, se[3]}, 16'h0);
    chk("midrst_busy", {15'h0, bz[3]}, 16'h0);
    frame(3, 16'h0015, 5, 1'b0, 1'b0, 1'b1, 16'h0015, 1'b0, 1'b0, -1, 1'b0);

    repeat (5) tick();
    for (int i = 0; i < 4; i++)
      chk($sformatf("queue_drained[%0d]", i), 16'(exp_q[i].size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_deser_param.md
Name: uart_rx_deser_param

Overview:
- Parametrised successor to the UART RX deserializer.
- Owns its own bit counter instead of taking one from the FSM.
- Supports configurable data width, LSB-/MSB-first order, optional odd/even parity check and stop-bit check.
- Sits between the RX edge/sample block (provides sample_valid/sampled_bit) and the frame consumer; emits a one-cycle data_valid with error flags per frame.

Parameters:
- DATA_W, 8, data bits per frame (5..16).
- MSB_FIRST, 0, 0 = first data bit lands in p_data[0]; 1 = first data bit lands in p_data[DATA_W-1].
- PARITY_EN, 0, 1 = one parity bit follows the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  pulse: start bit confirmed, begin frame
- abort  input  1  drop the current frame, return to IDLE
- sampled_bit  input  1  majority-sampled line value
- sample_valid  input  1  sampled_bit is valid this cycle (one pulse per bit period)
- p_data  output  DATA_W  last completed frame's data
- data_valid  output  1  one-cycle pulse, frame complete
- par_err  output  1  parity mismatch for the frame flagged by data_valid
- stop_err  output  1  stop bit sampled 0 for the frame flagged by data_valid
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset (reset=1 at a clk edge): state=IDLE, bit counter=0, shift register=0, p_data=0, data_valid=0, par_err=0, stop_err=0, busy=0. Reset mid-frame discards the frame; no data_valid is issued.
- States: IDLE, DATA, PARITY, STOP.
- IDLE -> DATA on start=1; counter cleared. start outside IDLE is ignored. sample_valid in IDLE is ignored.
- DATA: each sample_valid stores sampled_bit at index cnt (MSB_FIRST=0) or DATA_W-1-cnt (MSB_FIRST=1), then cnt++.
  - On the DATA_W-th sample, go to PARITY if PARITY_EN=1, else STOP.
  - Counter width is clog2(DATA_W+1); it never wraps within a frame.
- PARITY: the next sample_valid captures the parity bit.
  - Expected bit = XOR of the data bits (even), inverted for odd.
  - Mismatch sets an internal pending-parity-error; then go to STOP.
- STOP: the next sample_valid captures the stop bit; go to IDLE.
  - On that same edge: p_data <= shift register; par_err <= pending-parity-error (0 when PARITY_EN=0); stop_err <= ~sampled_bit; data_valid <= 1.
  - Latency: data_valid is high in the cycle after the stop-bit sample cycle, for exactly one cycle.
- The frame is delivered even with errors; the consumer decides whether to drop it.
- p_data, par_err and stop_err hold until the next completed frame.
- abort=1 in any state: next state IDLE, counter cleared, no data_valid, p_data unchanged. abort takes priority over start and sample_valid in the same cycle.
- start and the final stop sample_valid in the same cycle (back-to-back frames):
  - complete the current frame (data_valid next cycle);
  - start is ignored because the state is not IDLE;
  - the upstream FSM must reassert start after busy falls.
- sample_valid held high for multiple cycles counts one bit per cycle. The upstream block guarantees pulses, so no edge detection is done here.
- busy deasserts on the same edge data_valid asserts.

Test Plan:
- Defaults: start, then bits 1,0,1,1,0,0,1,0 (LSB first) plus stop=1 -> p_data=8'h4D, data_valid one cycle after the stop sample, par_err=0, stop_err=0, busy low.
- MSB_FIRST=1, DATA_W=8, same bit stream -> p_data=8'hB2.
- PARITY_EN=1, PARITY_ODD=0, data 8'h4D (four ones):
  - parity bit 0, stop 1 -> par_err=0;
  - repeat with parity bit 1 -> par_err=1, p_data=8'h4D still delivered.
- Stop bit sampled 0 -> stop_err=1, data_valid=1; the next good frame clears stop_err to 0.
- abort after 4 data bits, then a full frame 8'hA5 -> exactly one data_valid, p_data=8'hA5, no stale bits from the aborted frame.
- reset asserted mid-DATA with DATA_W=5 -> all outputs 0 next cycle; a following 5-bit frame 5'h15 yields p_data=5'h15.
